// File: rtl/ir_fetch_unit.sv
// rtl/ir_fetch_unit.sv - instruction fetch front end with prefetch buffer and redirect handling
module ir_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              ir_ready,
  output logic              load_ir,
  output logic [7:0]        data_on_ir,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // FETCH is normal operation; DISCARD swallows the ack of a request abandoned by a redirect
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t           state;
  logic [7:0]       buf_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;

  // Buffer traffic this cycle; a redirect suppresses both, since the buffer is being flushed
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;
    push       = (state == FETCH) && mem_rd && mem_ack && !pc_load;
    pop        = ir_ready && (count != '0) && !pc_load;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Prefetch storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_mem[tail] <= mem_data;
    end
  end

  // Request FSM, buffer pointers and registered IR delivery
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      mem_rd     <= 1'b0;
      mem_addr   <= RESET_PC;
      load_ir    <= 1'b0;
      data_on_ir <= 8'h00;
      buf_empty  <= 1'b1;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      load_ir <= 1'b0;
      if (pop) begin
        load_ir    <= 1'b1;
        data_on_ir <= buf_mem[head];
        head       <= head + 1'b1;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end

      if (pc_load) begin
        // Redirect: flush buffer, retarget, and track any request still in flight
        mem_addr  <= pc_new;
        mem_rd    <= 1'b0;
        count     <= '0;
        head      <= '0;
        tail      <= '0;
        buf_empty <= 1'b1;
        if (state == FETCH && mem_rd && !mem_ack) begin
          state <= DISCARD;
        end else if (state == DISCARD && mem_ack) begin
          state <= FETCH;
        end
      end else begin
        count     <= count_next;
        buf_empty <= (count_next == '0);
        case (state)
          FETCH: begin
            if (mem_rd) begin
              // Hold the request until acked, then idle one cycle before the next
              if (mem_ack) begin
                mem_rd   <= 1'b0;
                mem_addr <= mem_addr + 1'b1;
              end
            end else begin
              mem_rd <= (count_next < DEPTH_C);
            end
          end
          DISCARD: begin
            mem_rd <= 1'b0;
            if (mem_ack) begin
              state <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb/tb_ir_fetch_unit.sv - self-checking bench for ir_fetch_unit against a byte-stream memory model
module tb_ir_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       ir_ready = 1'b0;
  logic       load_ir;
  logic [7:0] data_on_ir;
  logic       pc_load = 1'b0;
  logic [7:0] pc_new = 8'h00;
  logic       buf_empty;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_img [256];
  int         lat_fixed = 0;
  int         lat_max = 0;
  bit         busy = 1'b0;
  int         wait_cnt = 0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] got_q [$];
  logic [7:0] acked_q [$];

  ir_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .ir_ready(ir_ready),
    .load_ir(load_ir), .data_on_ir(data_on_ir), .pc_load(pc_load),
    .pc_new(pc_new), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  // Program memory model plus IR monitor
  always @(negedge clk) begin
    if (load_ir) got_q.push_back(data_on_ir);
    mem_ack = 1'b0;
    if (reset) begin
      busy = 1'b0;
    end else begin
      if (!busy && mem_rd) begin
        busy     = 1'b1;
        req_addr = mem_addr;
        wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max, 0));
      end
      if (busy) begin
        if (wait_cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem_img[req_addr];
          acked_q.push_back(req_addr);
          busy     = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect_idle(input logic [7:0] tgt, output bit ok);
    int n;
    n = 0;
    while ((mem_rd || mem_ack || busy) && n < 30) begin
      tick();
      n++;
    end
    ok = !(mem_rd || mem_ack || busy);
    pc_load = 1'b1;
    pc_new  = tgt;
    got_q.delete();
    acked_q.delete();
    tick();
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_ready = 1'b0; pc_load = 1'b0; lat_fixed = 0;
    tick(); tick();
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %02h expected 00", mem_addr); end
    tests++; if (load_ir !== 1'b0) begin fails++; $display("FAIL reset_load_ir: got %b expected 0", load_ir); end
    tests++; if (data_on_ir !== 8'h00) begin fails++; $display("FAIL reset_data_on_ir: got %02h expected 00", data_on_ir); end
    tests++; if (buf_empty !== 1'b1) begin fails++; $display("FAIL reset_buf_empty: got %b expected 1", buf_empty); end
  endtask

  task automatic test_basic();
    logic [7:0] g;
    got_q.delete(); acked_q.delete();
    ir_ready = 1'b1; lat_fixed = 0; reset = 1'b0;
    tick();
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      fails++; $display("FAIL basic_first_req: got rd=%b addr=%02h expected rd=1 addr=00", mem_rd, mem_addr);
    end
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      tests++; if (g !== 8'hA0 + 8'(i)) begin fails++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, g, 8'hA0 + 8'(i)); end
    end
    for (int i = 0; i < 4; i++) begin
      g = (i < acked_q.size()) ? acked_q[i] : 8'hxx;
      tests++; if (g !== 8'(i)) begin fails++; $display("FAIL basic_addr%0d: got %02h expected %02h", i, g, 8'(i)); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] g;
    reset = 1'b1; tick(); tick();
    got_q.delete(); acked_q.delete();
    reset = 1'b0; ir_ready = 1'b0; lat_fixed = 0;
    repeat (10) tick();
    tests++; if (mem_rd !== 1'b0 || mem_addr !== 8'h02) begin
      fails++; $display("FAIL hold_stall: got rd=%b addr=%02h expected rd=0 addr=02", mem_rd, mem_addr);
    end
    tests++; if (acked_q.size() != 2 || got_q.size() != 0 || buf_empty !== 1'b0) begin
      fails++; $display("FAIL hold_fill: got fetched=%0d delivered=%0d empty=%b expected 2 0 0", acked_q.size(), got_q.size(), buf_empty);
    end
    ir_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      tests++; if (g !== mem_img[i]) begin fails++; $display("FAIL hold_byte%0d: got %02h expected %02h", i, g, mem_img[i]); end
    end
    g = (acked_q.size() > 2) ? acked_q[2] : 8'hxx;
    tests++; if (g !== 8'h02) begin fails++; $display("FAIL hold_resume: got %02h expected 02", g); end
  endtask

  task automatic test_discard();
    bit ok;
    int n;
    logic [7:0] g;
    lat_fixed = 3; ir_ready = 1'b1;
    redirect_idle(8'h05, ok);
    n = 0;
    while (!(mem_rd && mem_addr == 8'h05) && n < 20) begin tick(); n++; end
    tests++; if (!ok || !(mem_rd && mem_addr == 8'h05 && !mem_ack)) begin
      fails++; $display("FAIL discard_setup: got rd=%b addr=%02h ack=%b expected rd=1 addr=05 ack=0", mem_rd, mem_addr, mem_ack);
    end
    pc_load = 1'b1; pc_new = 8'h40; got_q.delete();
    tick();
    pc_load = 1'b0;
    tests++; if (load_ir !== 1'b0 || mem_rd !== 1'b0) begin
      fails++; $display("FAIL discard_after_redirect: got load_ir=%b rd=%b expected 0 0", load_ir, mem_rd);
    end
    n = 0;
    while (!mem_rd && n < 15) begin tick(); n++; end
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin
      fails++; $display("FAIL discard_next_req: got rd=%b addr=%02h expected rd=1 addr=40", mem_rd, mem_addr);
    end
    lat_fixed = -1; lat_max = 2;
    repeat (25) tick();
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      tests++; if (g !== mem_img[8'h40 + 8'(i)]) begin fails++; $display("FAIL discard_byte%0d: got %02h expected %02h", i, g, mem_img[8'h40 + 8'(i)]); end
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int n;
    logic [7:0] g;
    lat_fixed = 0; ir_ready = 1'b0;
    redirect_idle(8'h80, ok);
    n = 0;
    while (!(mem_ack && !buf_empty) && n < 20) begin tick(); n++; end
    tests++; if (!ok || !(mem_ack && !buf_empty)) begin
      fails++; $display("FAIL same_setup: got ack=%b empty=%b expected ack=1 empty=0", mem_ack, buf_empty);
    end
    pc_load = 1'b1; pc_new = 8'h10; ir_ready = 1'b1; got_q.delete();
    tick();
    pc_load = 1'b0;
    tests++; if (load_ir !== 1'b0 || buf_empty !== 1'b1 || mem_rd !== 1'b0) begin
      fails++; $display("FAIL same_after_redirect: got load_ir=%b empty=%b rd=%b expected 0 1 0", load_ir, buf_empty, mem_rd);
    end
    tick();
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'h10) begin
      fails++; $display("FAIL same_next_req: got rd=%b addr=%02h expected rd=1 addr=10", mem_rd, mem_addr);
    end
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      tests++; if (g !== mem_img[8'h10 + 8'(i)]) begin fails++; $display("FAIL same_byte%0d: got %02h expected %02h", i, g, mem_img[8'h10 + 8'(i)]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] g;
    logic [7:0] a;
    lat_fixed = -1; lat_max = 2; ir_ready = 1'b1;
    redirect_idle(8'hFD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_setup: got busy memory expected idle"); end
    repeat (30) tick();
    for (int i = 0; i < 6; i++) begin
      a = 8'hFD + 8'(i);
      g = (i < acked_q.size()) ? acked_q[i] : 8'hxx;
      tests++; if (g !== a) begin fails++; $display("FAIL wrap_addr%0d: got %02h expected %02h", i, g, a); end
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      tests++; if (g !== mem_img[a]) begin fails++; $display("FAIL wrap_byte%0d: got %02h expected %02h", i, g, mem_img[a]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    lat_fixed = 2; ir_ready = 1'b0;
    redirect_idle(8'h20, ok);
    n = 0;
    while (!(mem_rd && !buf_empty) && n < 20) begin tick(); n++; end
    tests++; if (!ok || !(mem_rd && !buf_empty)) begin
      fails++; $display("FAIL resetmid_setup: got rd=%b empty=%b expected rd=1 empty=0", mem_rd, buf_empty);
    end
    reset = 1'b1;
    tick();
    tests++; if (mem_rd !== 1'b0 || load_ir !== 1'b0 || buf_empty !== 1'b1 || mem_addr !== 8'h00) begin
      fails++; $display("FAIL resetmid_state: got rd=%b load=%b empty=%b addr=%02h expected 0 0 1 00", mem_rd, load_ir, buf_empty, mem_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] base;
    logic [7:0] mul;
    logic [7:0] off;
    bit         do_redir;
    int         bad_k;
    int         total;
    logic       prev_rd, prev_ack, prev_pcl;
    logic [7:0] prev_addr;
    mul = 8'($urandom) | 8'h01;
    off = 8'($urandom);
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(i) * mul + off;
    reset = 1'b1; pc_load = 1'b0; tick(); tick();
    lat_fixed = -1; lat_max = 3;
    got_q.delete(); base = 8'h00; total = 0;
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      do_redir = (c == 399) || ($urandom_range(0, 24) == 0);
      if (do_redir) begin
        bad_k = -1;
        foreach (got_q[k]) if (bad_k < 0 && got_q[k] !== mem_img[8'(base + 8'(k))]) bad_k = k;
        tests++; if (bad_k >= 0) begin
          fails++; $display("FAIL random_stream: base %02h byte %0d got %02h expected %02h", base, bad_k, got_q[bad_k], mem_img[8'(base + 8'(bad_k))]);
        end
        total += got_q.size();
        base = 8'($urandom);
        got_q.delete();
      end
      ir_ready = ($urandom_range(0, 3) != 0);
      pc_load  = do_redir && (c != 399);
      pc_new   = base;
      prev_rd = mem_rd; prev_ack = mem_ack; prev_pcl = pc_load; prev_addr = mem_addr;
      tick();
      if (prev_rd && !prev_ack && !prev_pcl) begin
        tests++; if (mem_rd !== 1'b1 || mem_addr !== prev_addr) begin
          fails++; $display("FAIL random_hold: got rd=%b addr=%02h expected rd=1 addr=%02h", mem_rd, mem_addr, prev_addr);
        end
      end
    end
    pc_load = 1'b0;
    tests++; if (total < 20) begin fails++; $display("FAIL random_progress: got %0d bytes expected at least 20", total); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 8'hA0 + 8'(i);
    test_reset();
    test_basic();
    test_hold();
    test_discard();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction fetch front end for the 8-bit core.
- Reads instruction bytes from program memory over a request/acknowledge handshake and keeps them in a small prefetch buffer.
- Delivers one byte at a time to the instruction register as a single-cycle load_ir strobe with data_on_ir.
- Handles PC redirects (jumps/branches) by flushing the buffer and discarding any in-flight memory response.

Parameters:
- ADDR_W, 8: width of fetch address and PC.
- RESET_PC, 8'h00: fetch address after reset.
- DEPTH, 2: prefetch buffer entries (power of two, 2..4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_rd  output  1  read request to program memory; registered.
- mem_addr  output  ADDR_W  fetch address; registered; stable while mem_rd=1.
- mem_ack  input  1  memory acknowledge; mem_data valid in the same cycle.
- mem_data  input  8  instruction byte from memory.
- ir_ready  input  1  decoder can accept the next instruction byte.
- load_ir  output  1  one-cycle strobe to the IR load enable; registered.
- data_on_ir  output  8  byte for the IR; registered; valid when load_ir=1.
- pc_load  input  1  redirect request from the control unit.
- pc_new  input  ADDR_W  redirect target.
- buf_empty  output  1  prefetch buffer empty.

Behaviour:
- Reset values: mem_rd=0, mem_addr=RESET_PC, load_ir=0, data_on_ir=8'h00, buf_empty=1, count=0, FSM=FETCH. The first mem_rd=1 appears in the cycle after reset deasserts.
- FSM states:
  - FETCH: normal operation.
  - DISCARD: waiting for a stale acknowledge.
- FETCH request rules:
  - mem_rd=1 whenever count + outstanding < DEPTH.
  - Once raised, mem_rd and mem_addr hold until mem_ack; there is at most 1 request outstanding.
- On mem_ack with mem_rd=1:
  - mem_data is written to the buffer tail, count+1, mem_addr+1.
  - mem_addr wraps 8'hFF -> 8'h00.
  - mem_rd drops for one cycle, then re-asserts if there is room. This gives 2-cycle minimum per byte, with the ack in the same cycle as the request at best.
- mem_ack while mem_rd=0 in FETCH is ignored.
- Delivery:
  - If ir_ready=1 and the buffer is non-empty at edge N, then at N+1 load_ir=1, data_on_ir=head byte, and the entry is popped.
  - Otherwise load_ir=0 and data_on_ir holds its last value.
  - Bytes are delivered in address order, one per cycle maximum.
- Same-cycle events: a push (ack) and a pop (delivery) in the same cycle leave count unchanged. A full buffer blocks requests, never pops.
- pc_load=1 (highest priority over everything except reset):
  - mem_addr <= pc_new; buffer cleared (count=0, buf_empty=1).
  - No load_ir in the following cycle, even if ir_ready=1.
  - If mem_rd=1 and mem_ack=0 that cycle: mem_rd <= 0, go to DISCARD.
  - If mem_ack=1 that same cycle: that byte is dropped and the FSM stays in FETCH.
- DISCARD:
  - mem_rd=0; wait for mem_ack, drop its mem_data, return to FETCH.
  - The request for pc_new issues in the next cycle.
  - A further pc_load in DISCARD updates mem_addr and stays in DISCARD.
- Reset mid-transaction: all state returns to reset values immediately. Memory is required to tolerate the abandoned request.
- buf_empty is registered and reflects count==0 after the edge.

Test Plan:
- Reset, then memory returns 8'hA0,8'hA1,8'hA2 at 0x00..0x02 with 1-cycle ack, ir_ready=1 -> mem_rd high the cycle after reset; load_ir pulses carry A0,A1,A2 in order; mem_addr steps 00,01,02,03.
- Hold ir_ready=0 -> exactly DEPTH=2 bytes fetched, then mem_rd stays 0 with mem_addr=0x02. Raise ir_ready -> two load_ir pulses (bytes of 0x00,0x01), and fetching resumes at 0x02.
- Assert pc_load with pc_new=8'h40 while a request to 0x05 is outstanding with ack delayed 3 cycles -> DISCARD; the stale byte never reaches load_ir; the next request is mem_addr=0x40; the first delivered byte is from 0x40.
- pc_load and mem_ack in the same cycle, pc_new=8'h10 -> acked byte dropped; no DISCARD; next mem_rd at 0x10; no load_ir in the following cycle.
- Fetch across the 0xFF boundary -> after 0xFF the next mem_addr is 0x00, and bytes are delivered in order.
- Assert reset while mem_rd=1 and the buffer holds 1 byte -> the next cycle has mem_rd=0, load_ir=0, buf_empty=1, mem_addr=RESET_PC.
